// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch / PC controller for the sequential core.
// Owns the PC and walks each instruction through FETCH -> EXEC -> PC update,
// one instruction in flight. All outputs come straight from registers.
module pc_sequencer #(
   parameter int unsigned     XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     ACK_TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [31:0]     imem_rdata_i,
   output logic            instr_valid_o,
   output logic [31:0]     instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   input  logic            exec_done_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_immd_i,
   input  logic            stall_i,
   output logic            fetch_fault_o
);

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   // Last no-ack FETCH cycle count before the request is declared dead.
   localparam logic [7:0]      TIMEOUT_LAST = 8'(ACK_TIMEOUT - 32'd1);
   localparam logic [XLEN-1:0] PC_STEP      = XLEN'(3'd4);

   state_e            state_q;
   logic [XLEN-1:0]   pc_q;
   logic [7:0]        cnt_q;
   logic              imem_req_q;
   logic [XLEN-1:0]   imem_addr_q;
   logic              instr_valid_q;
   logic [31:0]       instr_q;
   logic [XLEN-1:0]   instr_pc_q;
   logic              fetch_fault_q;

   logic [XLEN-1:0]   nxt_pc_d;
   logic              misaligned_d;

   // Next-address datapath: PC+4 or PC+immd (wraps modulo 2^XLEN), plus alignment check.
   always_comb begin
      nxt_pc_d     = pc_q + PC_STEP;
      misaligned_d = 1'b0;
      if (branch_taken_i) begin
         nxt_pc_d = pc_q + branch_immd_i;
      end else begin
         nxt_pc_d = pc_q + PC_STEP;
      end
      misaligned_d = |nxt_pc_d[1:0];
   end

   // Sequencer FSM with registered outputs; HALT is sticky until rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_VECTOR;
         cnt_q         <= 8'd0;
         imem_req_q    <= 1'b0;
         imem_addr_q   <= '0;
         instr_valid_q <= 1'b0;
         instr_q       <= 32'd0;
         instr_pc_q    <= '0;
         fetch_fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               if (stall_i) begin
                  state_q <= ST_HOLD;
               end else begin
                  state_q     <= ST_FETCH;
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= pc_q;
               end
            end
            ST_FETCH: begin
               if (imem_ack_i) begin
                  // An ack on the timeout cycle still wins.
                  state_q       <= ST_EXEC;
                  instr_q       <= imem_rdata_i;
                  instr_pc_q    <= pc_q;
                  cnt_q         <= 8'd0;
                  imem_req_q    <= 1'b0;
                  imem_addr_q   <= '0;
                  instr_valid_q <= 1'b1;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  state_q       <= ST_HALT;
                  cnt_q         <= 8'd0;
                  imem_req_q    <= 1'b0;
                  imem_addr_q   <= '0;
                  instr_q       <= 32'd0;
                  instr_pc_q    <= '0;
                  fetch_fault_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_EXEC: begin
               if (exec_done_i) begin
                  instr_valid_q <= 1'b0;
                  if (misaligned_d) begin
                     // PC is left at the faulting instruction for post-mortem.
                     state_q       <= ST_HALT;
                     instr_q       <= 32'd0;
                     instr_pc_q    <= '0;
                     fetch_fault_q <= 1'b1;
                  end else if (stall_i) begin
                     state_q <= ST_HOLD;
                     pc_q    <= nxt_pc_d;
                  end else begin
                     state_q     <= ST_FETCH;
                     pc_q        <= nxt_pc_d;
                     imem_req_q  <= 1'b1;
                     imem_addr_q <= nxt_pc_d;
                  end
               end else begin
                  instr_valid_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (!stall_i) begin
                  state_q     <= ST_FETCH;
                  imem_req_q  <= 1'b1;
                  imem_addr_q <= pc_q;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            ST_HALT: begin
               state_q       <= ST_HALT;
               imem_req_q    <= 1'b0;
               imem_addr_q   <= '0;
               instr_valid_q <= 1'b0;
               instr_q       <= 32'd0;
               instr_pc_q    <= '0;
               fetch_fault_q <= 1'b1;
            end
            default: begin
               // Corrupted state encoding: stop the core safely.
               state_q       <= ST_HALT;
               imem_req_q    <= 1'b0;
               imem_addr_q   <= '0;
               instr_valid_q <= 1'b0;
               fetch_fault_q <= 1'b1;
            end
         endcase
      end
   end

   assign imem_req_o    = imem_req_q;
   assign imem_addr_o   = imem_addr_q;
   assign instr_valid_o = instr_valid_q;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign fetch_fault_o = fetch_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of instructions with hand-computed
// fetch addresses, followed by hand-written timeout, misalignment, stall and
// asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_immd = 64'd0;
   logic        stall = 1'b0;
   logic        fetch_fault;

   int n_vec = 0;
   int n_err = 0;

   pc_sequencer #(.XLEN(64), .RESET_VECTOR(64'd0), .ACK_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
      .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
      .exec_done_i(exec_done), .branch_taken_i(branch_taken),
      .branch_immd_i(branch_immd), .stall_i(stall),
      .fetch_fault_o(fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] exp_addr;
      logic [31:0] rdata;
      logic        taken;
      logic [63:0] immd;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (imem_req !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check({name, " req"}, {63'd0, imem_req}, 64'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; imem_ack = 1'b0; exec_done = 1'b0; stall = 1'b0;
      branch_taken = 1'b0; branch_immd = 64'd0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic do_instr(input string name, input logic [63:0] exp_addr, input logic [31:0] rdata,
                           input logic taken, input logic [63:0] immd, input logic stl);
      wait_req(name);
      check({name, " addr"}, imem_addr, exp_addr);
      imem_ack = 1'b1; imem_rdata = rdata;
      step();
      imem_ack = 1'b0; imem_rdata = 32'd0;
      check({name, " valid"}, {63'd0, instr_valid}, 64'd1);
      check({name, " instr"}, {32'd0, instr}, {32'd0, rdata});
      check({name, " instr_pc"}, instr_pc, exp_addr);
      check({name, " req_low"}, {63'd0, imem_req}, 64'd0);
      exec_done = 1'b1; branch_taken = taken; branch_immd = immd; stall = stl;
      step();
      exec_done = 1'b0; branch_taken = 1'b0; branch_immd = 64'd0;
      check({name, " valid_drop"}, {63'd0, instr_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{64'h0,                   32'h0000_0013, 1'b0, 64'h0};
      vecs[1] = '{64'h4,                   32'h0010_0093, 1'b0, 64'h0};
      vecs[2] = '{64'h8,                   32'h0020_0113, 1'b1, 64'h0000_0000_0000_00F8};
      vecs[3] = '{64'h100,                 32'hDEAD_BEEF, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8};
      vecs[4] = '{64'hF8,                  32'hCAFE_F00D, 1'b1, 64'hFFFF_FFFF_FFFF_FF04};
      vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_5678, 1'b0, 64'h0};
      vecs[6] = '{64'h0,                   32'h8765_4321, 1'b0, 64'h0};

      // Reset state
      rst_n = 1'b0;
      step();
      check("rst req", {63'd0, imem_req}, 64'd0);
      check("rst addr", imem_addr, 64'd0);
      check("rst valid", {63'd0, instr_valid}, 64'd0);
      check("rst instr", {32'd0, instr}, 64'd0);
      check("rst instr_pc", instr_pc, 64'd0);
      check("rst fault", {63'd0, fetch_fault}, 64'd0);
      step();
      rst_n = 1'b1;

      // Instruction table: sequential, branches, negative offset, wrap-around
      for (int i = 0; i < 7; i++) begin
         do_instr($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].rdata,
                  vecs[i].taken, vecs[i].immd, 1'b0);
         check($sformatf("vec%0d next_req", i), {63'd0, imem_req}, 64'd1);
         check($sformatf("vec%0d fault", i), {63'd0, fetch_fault}, 64'd0);
      end

      // Ack on the final allowed cycle is captured, no fault
      wait_req("late_ack");
      check("late_ack addr", imem_addr, 64'h4);
      for (int i = 0; i < 14; i++) step();
      imem_ack = 1'b1; imem_rdata = 32'hA5A5_5A5A;
      step();
      imem_ack = 1'b0;
      check("late_ack valid", {63'd0, instr_valid}, 64'd1);
      check("late_ack instr", {32'd0, instr}, 64'h0000_0000_A5A5_5A5A);
      check("late_ack fault", {63'd0, fetch_fault}, 64'd0);
      exec_done = 1'b1;
      step();
      exec_done = 1'b0;

      // Ack withheld for the full timeout -> sticky fault, HALT
      wait_req("tmo");
      check("tmo addr", imem_addr, 64'h8);
      for (int i = 0; i < 14; i++) step();
      check("tmo req_before", {63'd0, imem_req}, 64'd1);
      check("tmo fault_before", {63'd0, fetch_fault}, 64'd0);
      step();
      check("tmo fault", {63'd0, fetch_fault}, 64'd1);
      check("tmo req", {63'd0, imem_req}, 64'd0);
      check("tmo addr_zero", imem_addr, 64'd0);
      imem_ack = 1'b1; exec_done = 1'b1;
      for (int i = 0; i < 3; i++) step();
      imem_ack = 1'b0; exec_done = 1'b0;
      check("halt fault", {63'd0, fetch_fault}, 64'd1);
      check("halt req", {63'd0, imem_req}, 64'd0);
      check("halt valid", {63'd0, instr_valid}, 64'd0);

      // Misaligned branch target 0x40 + 6
      do_reset();
      check("mis rst fault", {63'd0, fetch_fault}, 64'd0);
      do_instr("mis0", 64'h0, 32'h1111_1111, 1'b1, 64'h40, 1'b0);
      do_instr("mis1", 64'h40, 32'h2222_2222, 1'b1, 64'h6, 1'b0);
      check("mis fault", {63'd0, fetch_fault}, 64'd1);
      check("mis req", {63'd0, imem_req}, 64'd0);
      for (int i = 0; i < 5; i++) step();
      check("mis req_later", {63'd0, imem_req}, 64'd0);

      // Stall at exec_done holds off the next fetch until it drops
      do_reset();
      do_instr("stl", 64'h0, 32'h3333_3333, 1'b0, 64'h0, 1'b1);
      check("stl req0", {63'd0, imem_req}, 64'd0);
      for (int i = 0; i < 3; i++) step();
      check("stl req3", {63'd0, imem_req}, 64'd0);
      stall = 1'b0;
      step();
      check("stl resume req", {63'd0, imem_req}, 64'd1);
      check("stl resume addr", imem_addr, 64'h4);

      // Asynchronous reset mid-FETCH
      #1 rst_n = 1'b0;
      #1;
      check("arst_f req", {63'd0, imem_req}, 64'd0);
      check("arst_f addr", imem_addr, 64'd0);
      step();
      rst_n = 1'b1;
      wait_req("arst_f refetch");
      check("arst_f refetch addr", imem_addr, 64'h0);

      // Asynchronous reset mid-EXEC
      imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
      step();
      imem_ack = 1'b0;
      check("arst_e valid_pre", {63'd0, instr_valid}, 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_e valid", {63'd0, instr_valid}, 64'd0);
      check("arst_e instr", {32'd0, instr}, 64'd0);
      check("arst_e instr_pc", instr_pc, 64'd0);
      step();
      rst_n = 1'b1;
      wait_req("arst_e refetch");
      check("arst_e refetch addr", imem_addr, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
